// File: rtl/uart_pkg.sv
// Shared UART Tx definitions: parity encodings, frame sequencer states, data width.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_ODD      = 2'b01;
  localparam logic [1:0] PARITY_EVEN     = 2'b10;
  localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic parity_used(input logic [1:0] ptype);
    return !((ptype == PARITY_NONE) || (ptype == PARITY_NONE_ALT));
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational frame parity bit: even = XOR of the byte, odd = its inverse.
import uart_pkg::*;

module uart_parity_gen (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        ptype_i,
  output logic              parity_o
);

  always_comb begin
    parity_o = (ptype_i == PARITY_ODD) ? ~(^data_i) : (^data_i);
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART Tx frame sequencer: start, 8 data bits LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_HOLD_BUFFER_EN for a one-entry request holding register (adds HoldFull).
import uart_pkg::*;

module uart_tx_frame_ctrl (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              BaudTick,
  input  logic              Send,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [1:0]        ParityType,
  input  logic              StopBits,
  output logic              TxOut,
  output logic              Busy,
  output logic              Done
`ifdef UART_TX_HOLD_BUFFER_EN
  ,
  output logic              HoldFull
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [1:0]        ptype_q;
  logic              stop2_q;
  logic              par_q;
  logic              stop_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic              par_w;
  logic              last_tick;
  logic              start_d;
  logic [DATA_W-1:0] ld_data_d;
  logic [1:0]        ld_ptype_d;
  logic              ld_stop2_d;
  logic              ld_par_d;

  uart_parity_gen u_parity_gen (
    .data_i   (DataIn),
    .ptype_i  (ParityType),
    .parity_o (par_w)
  );

  assign last_tick = BaudTick && (state_q == ST_STOP) && (!stop2_q || stop_cnt_q);

`ifdef UART_TX_HOLD_BUFFER_EN
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [1:0]        hold_ptype_q;
  logic              hold_stop2_q;
  logic              hold_par_q;

  // A held request wins at frame end; with the holder empty, a Send on that edge starts directly.
  always_comb begin
    start_d    = 1'b0;
    ld_data_d  = DataIn;
    ld_ptype_d = ParityType;
    ld_stop2_d = StopBits;
    ld_par_d   = par_w;
    if (state_q == ST_IDLE) begin
      start_d = Send;
    end else if (last_tick) begin
      if (hold_full_q) begin
        start_d    = 1'b1;
        ld_data_d  = hold_data_q;
        ld_ptype_d = hold_ptype_q;
        ld_stop2_d = hold_stop2_q;
        ld_par_d   = hold_par_q;
      end else begin
        start_d = Send;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_ptype_q <= PARITY_NONE;
      hold_stop2_q <= 1'b0;
      hold_par_q   <= 1'b0;
    end else if (last_tick) begin
      hold_full_q <= 1'b0;
    end else if (busy_q && Send && !hold_full_q) begin
      hold_full_q  <= 1'b1;
      hold_data_q  <= DataIn;
      hold_ptype_q <= ParityType;
      hold_stop2_q <= StopBits;
      hold_par_q   <= par_w;
    end
  end

  assign HoldFull = hold_full_q;
`else
  always_comb begin
    start_d    = (state_q == ST_IDLE) && Send;
    ld_data_d  = DataIn;
    ld_ptype_d = ParityType;
    ld_stop2_d = StopBits;
    ld_par_d   = par_w;
  end
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      ptype_q    <= PARITY_NONE;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_ARMED: if (BaudTick) begin
          state_q <= ST_START;
          tx_q    <= 1'b0;
        end
        ST_START: if (BaudTick) begin
          state_q   <= ST_DATA;
          tx_q      <= shift_q[0];
          bit_cnt_q <= '0;
        end
        ST_DATA: if (BaudTick) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            stop_cnt_q <= 1'b0;
            if (parity_used(ptype_q)) begin
              state_q <= ST_PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            shift_q   <= shift_q >> 1;
            tx_q      <= shift_q[1];
          end
        end
        ST_PARITY: if (BaudTick) begin
          state_q <= ST_STOP;
          tx_q    <= 1'b1;
        end
        ST_STOP: begin
          if (last_tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (BaudTick) begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (start_d) begin
        state_q <= ST_ARMED;
        busy_q  <= 1'b1;
        shift_q <= ld_data_d;
        ptype_q <= ld_ptype_d;
        stop2_q <= ld_stop2_d;
        par_q   <= ld_par_d;
      end
    end
  end

  assign TxOut = tx_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: frame-level line model checked every cycle plus literal frame captures.
module tb_uart_tx_frame_ctrl;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       BaudTick = 1'b0;
  logic       Send;
  logic [7:0] DataIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       TxOut;
  logic       Busy;
  logic       Done;
`ifdef UART_TX_HOLD_BUFFER_EN
  logic       HoldFull;
`endif

  int asserts = 0;
  int fails   = 0;
  int tick_cnt = 0;

  uart_tx_frame_ctrl dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .BaudTick   (BaudTick),
    .Send       (Send),
    .DataIn     (DataIn),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .TxOut      (TxOut),
    .Busy       (Busy),
    .Done       (Done)
`ifdef UART_TX_HOLD_BUFFER_EN
    ,
    .HoldFull   (HoldFull)
`endif
  );

  always #5 Clock = ~Clock;

  // One BaudTick every 16 clocks.
  always @(negedge Clock) begin
    tick_cnt = (tick_cnt == 15) ? 0 : tick_cnt + 1;
    BaudTick = (tick_cnt == 15);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Line bits of a whole frame, index 0 = start bit; bits beyond the frame length are 0.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    logic [11:0] b;
    int k;
    b = '0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    k = 9;
    if (pt == 2'b01 || pt == 2'b10) begin
      b[9] = (pt == 2'b10) ? ^d : ~(^d);
      k = 10;
    end
    b[k] = 1'b1;
    if (sb) b[k + 1] = 1'b1;
    return b;
  endfunction

  function automatic int frame_len(input logic [1:0] pt, input logic sb);
    return 10 + ((pt == 2'b01 || pt == 2'b10) ? 1 : 0) + (sb ? 1 : 0);
  endfunction

  // Frame-level model: after accept, each BaudTick moves to the next line bit.
  logic        m_busy, m_tx, m_done, m_hold;
  logic [11:0] m_bits, h_bits;
  int          m_len, h_len, m_idx;

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_busy = 1'b0; m_tx = 1'b1; m_done = 1'b0; m_hold = 1'b0; m_idx = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (Send) begin
          m_bits = frame_bits(DataIn, ParityType, StopBits);
          m_len  = frame_len(ParityType, StopBits);
          m_idx  = -1;
          m_busy = 1'b1;
        end
      end else begin
`ifdef UART_TX_HOLD_BUFFER_EN
        if (Send && !m_hold) begin
          h_bits = frame_bits(DataIn, ParityType, StopBits);
          h_len  = frame_len(ParityType, StopBits);
          m_hold = 1'b1;
        end
`endif
        if (BaudTick) begin
          m_idx++;
          if (m_idx == m_len) begin
            m_done = 1'b1;
            m_tx   = 1'b1;
            m_busy = 1'b0;
            if (m_hold) begin
              m_bits = h_bits; m_len = h_len; m_idx = -1; m_busy = 1'b1; m_hold = 1'b0;
            end
          end else begin
            m_tx = m_bits[m_idx];
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    check("cyc_txout", 32'(TxOut), 32'(m_tx));
    check("cyc_busy",  32'(Busy),  32'(m_busy));
    check("cyc_done",  32'(Done),  32'(m_done));
`ifdef UART_TX_HOLD_BUFFER_EN
    check("cyc_holdfull", 32'(HoldFull), 32'(m_hold));
`endif
  end

  // Called at a negedge(+1); accept happens on the following posedge.
  task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    DataIn = d; ParityType = pt; StopBits = sb; Send = 1'b1;
    @(negedge Clock); #1;
    Send = 1'b0;
  endtask

  // Samples the line mid-period from the start bit until Done; optional mid-frame Send or reset.
  task automatic collect(input logic [11:0] exp_bits, input int exp_len, input string name,
                         input bit inject, input int abort_at);
    logic [11:0] got;
    int  n;
    bit  started, done_seen;
    got = '0; n = 0; started = 0; done_seen = 0;
    for (int c = 0; c < 1000 && !done_seen; c++) begin
      @(negedge Clock); #1;
      if (Send) begin
        Send = 1'b0;
`ifdef UART_TX_HOLD_BUFFER_EN
        check({name, "_holdfull"}, 32'(HoldFull), 32'd1);
`endif
      end
      if (tick_cnt == 8 && (started || TxOut == 1'b0)) begin
        started = 1;
        if (n < 12) got[n] = TxOut;
        n++;
        if (inject && n == 5) begin
          DataIn = 8'hA9; ParityType = 2'b00; StopBits = 1'b0; Send = 1'b1;
        end
        if (abort_at != 0 && n == abort_at) begin
          #2 ResetN = 1'b0;
          #1;
          check({name, "_rst_txout"}, 32'(TxOut), 32'd1);
          check({name, "_rst_busy"},  32'(Busy),  32'd0);
          return;
        end
      end
      if (Done) done_seen = 1;
    end
    check({name, "_done_seen"}, 32'(done_seen), 32'd1);
    check({name, "_len"},  32'(n), 32'(exp_len));
    check({name, "_bits"}, 32'(got), 32'(exp_bits));
  endtask

  task automatic quiet(input int cycles, input string name);
    int dones;
    dones = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge Clock); #1;
      if (Done) dones++;
    end
    check({name, "_no_done"}, 32'(dones), 32'd0);
    check({name, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    ResetN = 1'b0; Send = 1'b0; DataIn = '0; ParityType = '0; StopBits = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    check("reset_txout", 32'(TxOut), 32'd1);
    check("reset_busy",  32'(Busy),  32'd0);
    check("reset_done",  32'(Done),  32'd0);
    ResetN = 1'b1;

    check("model_17",   32'(frame_bits(8'h17, 2'b00, 1'b0)), 32'h22E);
    check("model_01e",  32'(frame_bits(8'h01, 2'b10, 1'b0)), 32'h602);
    check("model_01o",  32'(frame_bits(8'h01, 2'b01, 1'b0)), 32'h402);
    check("model_af",   32'(frame_bits(8'hAF, 2'b11, 1'b1)), 32'h75E);
    check("model_len",  32'(frame_len(2'b10, 1'b1)), 32'd12);

    send(8'h17, 2'b00, 1'b0); collect(12'h22E, 10, "f17_8n1", 0, 0);
    quiet(40, "f17_after");
    send(8'h01, 2'b10, 1'b0); collect(12'h602, 11, "f01_even", 0, 0);
    send(8'h01, 2'b01, 1'b0); collect(12'h402, 11, "f01_odd", 0, 0);
    send(8'hAF, 2'b11, 1'b1); collect(12'h75E, 11, "faf_8n2", 0, 0);
    send(8'h17, 2'b00, 1'b0); collect(12'h22E, 10, "midsend", 1, 0);
`ifdef UART_TX_HOLD_BUFFER_EN
    collect(12'h352, 10, "held_a9", 0, 0);
`else
    quiet(40, "midsend_after");
`endif
    // Send issued in the Done cycle of the previous frame.
    send(8'h01, 2'b10, 1'b0); collect(12'h602, 11, "pre_done", 0, 0);
    send(8'hAF, 2'b11, 1'b1); collect(12'h75E, 11, "done_cycle", 0, 0);
    quiet(40, "done_cycle_after");
    // Reset during data bit 3.
    send(8'h17, 2'b00, 1'b0); collect(12'h0, 0, "abort", 0, 5);
    quiet(20, "in_reset");
    @(negedge Clock); #1;
    ResetN = 1'b1;
    quiet(40, "post_reset");
    send(8'hBD, 2'b10, 1'b0); collect(12'h57A, 11, "fbd_even", 0, 0);
    quiet(10, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
